// File: rtl/axis_lut_ram.sv
// Reloadable AXI-Stream lookup table: a write stream fills the RAM from address 0 and a read-address stream returns words with 1-cycle latency.
// Optional build macro: LUT_RANGE_CHECK_EN (out-of-range reads return 0 with m_axis_terr=1).
module axis_lut_ram #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int LAST_ENABLE = 1,
  parameter int USER_ENABLE = 1,
  parameter int USER_WIDTH  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_wr_tdata,
  input  logic                  s_axis_wr_tlast,
  input  logic                  s_axis_wr_tvalid,
  output logic                  s_axis_wr_tready,
  input  logic [ADDR_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic                  m_axis_terr,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  table_valid,
  output logic [ADDR_WIDTH:0]   table_depth,
  output logic                  overflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int EW    = DATA_WIDTH + USER_WIDTH + 2;
  localparam logic [ADDR_WIDTH:0]   FULL_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   DEPTH_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {EMPTY = 2'd0, LOAD = 2'd1, RUN = 2'd2} state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] wptr_reg, wptr_next, waddr;
  logic [ADDR_WIDTH:0]   depth_reg, depth_next, depth_base;
  logic                  overflow_reg, overflow_next;
  logic                  wr_fire, wr_end, write_grant;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  rd_valid_reg;
  logic [DATA_WIDTH-1:0] rd_data_reg;
  logic                  rd_last_reg;
  logic [USER_WIDTH-1:0] rd_user_reg;
  logic                  rd_err_reg;
  logic                  rd_fire, addr_oob, pipe_empty, pop, pop_buf, push;
  logic [2:0]            occ_after_pop;
  logic [1:0]            count_reg, count_next, count_after_pop;
  logic [EW-1:0]         skid0_reg, skid1_reg, inflight, head;

  // ---------------- load control ----------------
  assign pipe_empty       = ~rd_valid_reg & (count_reg == 2'd0);
  assign s_axis_wr_tready = (state_reg != RUN) | pipe_empty;
  assign wr_fire          = s_axis_wr_tvalid & s_axis_wr_tready;
  assign write_grant      = (state_reg == RUN) & s_axis_wr_tvalid & pipe_empty;

  always_comb begin
    state_next    = state_reg;
    wptr_next     = wptr_reg;
    depth_next    = depth_reg;
    overflow_next = overflow_reg;
    waddr         = wptr_reg;
    depth_base    = depth_reg;
    wr_end        = 1'b0;
    if (wr_fire) begin
      if (state_reg == LOAD) begin
        waddr         = wptr_reg;
        depth_base    = depth_reg;
        overflow_next = overflow_reg | ((wptr_reg == '0) & (depth_reg == FULL_DEPTH));
      end else begin
        // EMPTY or RUN: this beat opens a fresh load at address 0
        waddr         = '0;
        depth_base    = '0;
        overflow_next = 1'b0;
      end
      wptr_next  = waddr + ADDR_ONE;
      depth_next = (depth_base == FULL_DEPTH) ? FULL_DEPTH : depth_base + DEPTH_ONE;
      wr_end     = (LAST_ENABLE != 0) ? s_axis_wr_tlast : (waddr == '1);
      state_next = wr_end ? RUN : LOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= EMPTY;
      wptr_reg     <= '0;
      depth_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wptr_reg     <= wptr_next;
      depth_reg    <= depth_next;
      overflow_reg <= overflow_next;
    end
  end

  assign table_valid = (state_reg == RUN);
  assign table_depth = depth_reg;
  assign overflow    = overflow_reg;

  // ---------------- read path ----------------
  // Occupancy counts the RAM-register beat plus buffered beats; never exceeds 2.
  assign occ_after_pop = {2'b00, rd_valid_reg} + {1'b0, count_reg} - {2'b00, pop};
  assign s_axis_tready = (state_reg == RUN) & (occ_after_pop < 3'd2) & ~write_grant;
  assign rd_fire       = s_axis_tvalid & s_axis_tready;

`ifdef LUT_RANGE_CHECK_EN
  assign addr_oob = ({1'b0, s_axis_tdata} >= depth_reg);
`else
  assign addr_oob = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[waddr] <= s_axis_wr_tdata;
    end
    if (rd_fire) begin
      rd_data_reg <= mem[s_axis_tdata];
      rd_last_reg <= (LAST_ENABLE != 0) & s_axis_tlast;
      rd_user_reg <= (USER_ENABLE != 0) ? s_axis_tuser : '0;
      rd_err_reg  <= addr_oob;
    end
  end

  assign inflight = {rd_err_reg, rd_user_reg, rd_last_reg,
                     rd_err_reg ? DATA_WIDTH'(0) : rd_data_reg};

  // The RAM register drives the output directly when the skid buffer is empty,
  // which keeps the accept-to-valid latency at one cycle.
  assign head          = (count_reg != 2'd0) ? skid0_reg : inflight;
  assign m_axis_tvalid = rd_valid_reg | (count_reg != 2'd0);
  assign pop           = m_axis_tvalid & m_axis_tready;
  assign pop_buf       = pop & (count_reg != 2'd0);
  assign push          = rd_valid_reg & ~(pop & (count_reg == 2'd0));
  assign count_after_pop = count_reg - {1'b0, pop_buf};
  assign count_next      = count_after_pop + {1'b0, push};

  assign m_axis_tdata = m_axis_tvalid ? head[DATA_WIDTH-1:0] : '0;
  assign m_axis_tlast = m_axis_tvalid & head[DATA_WIDTH];
  assign m_axis_tuser = m_axis_tvalid ? head[DATA_WIDTH+1 +: USER_WIDTH] : '0;
  assign m_axis_terr  = m_axis_tvalid & head[EW-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_reg <= 1'b0;
      count_reg    <= 2'd0;
    end else begin
      rd_valid_reg <= rd_fire;
      count_reg    <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (pop_buf) begin
      skid0_reg <= skid1_reg;
    end
    if (push && count_after_pop == 2'd0) begin
      skid0_reg <= inflight;
    end
    if (push && count_after_pop == 2'd1) begin
      skid1_reg <= inflight;
    end
  end

endmodule

// File: tb/tb_axis_lut_ram.sv
// Directed + randomized bench for axis_lut_ram against a queue/array reference model.
module tb_axis_lut_ram;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] s_axis_wr_tdata = '0;
  logic       s_axis_wr_tlast = 1'b0;
  logic       s_axis_wr_tvalid = 1'b0;
  logic       s_axis_wr_tready;
  logic [7:0] s_axis_tdata = '0;
  logic       s_axis_tlast = 1'b0;
  logic [0:0] s_axis_tuser = '0;
  logic       s_axis_tvalid = 1'b0;
  logic       s_axis_tready;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tlast;
  logic [0:0] m_axis_tuser;
  logic       m_axis_terr;
  logic       m_axis_tvalid;
  logic       m_axis_tready = 1'b1;
  logic       table_valid;
  logic [8:0] table_depth;
  logic       overflow;

  always #5 clk = ~clk;

  axis_lut_ram dut (
    .clk(clk), .rst(rst),
    .s_axis_wr_tdata(s_axis_wr_tdata), .s_axis_wr_tlast(s_axis_wr_tlast),
    .s_axis_wr_tvalid(s_axis_wr_tvalid), .s_axis_wr_tready(s_axis_wr_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .m_axis_terr(m_axis_terr), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .table_valid(table_valid), .table_depth(table_depth), .overflow(overflow)
  );

  typedef struct {
    logic [7:0] d;
    logic       l;
    logic       u;
    logic       e;
  } beat_t;

  int         tests = 0;
  int         fails = 0;
  beat_t      q[$];
  logic [7:0] mmem [256];
  int         mdepth = 0;
  int         mwp = 0;
  bit         movf = 0;
  bit         mtv = 0;
  bit         mloading = 0;
  int         rdy_mode = 0;
  int         rdy_cnt = 0;
  bit         wr_fired = 0;
  bit         rd_fired = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: inputs are already driven; check outputs, observe handshakes, advance model.
  task automatic tick();
    bit    exp_mv, pop_e, exp_str, exp_wrr;
    int    occ;
    beat_t b;
    case (rdy_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = ((rdy_cnt % 4) == 0) || ((rdy_cnt % 4) == 3);
      2:       m_axis_tready = 1'($urandom_range(0, 1));
      default: m_axis_tready = 1'b0;
    endcase
    rdy_cnt++;
    #2;
    wr_fired = s_axis_wr_tvalid && s_axis_wr_tready;
    rd_fired = s_axis_tvalid && s_axis_tready;
    if (rst) begin
      q.delete();
      mdepth = 0; mwp = 0; movf = 0; mtv = 0; mloading = 0;
    end else begin
      exp_mv = (q.size() != 0);
      pop_e  = exp_mv && m_axis_tready;
      chk("m_tvalid", 32'(m_axis_tvalid), 32'(exp_mv));
      if (exp_mv) begin
        chk("m_tdata", 32'(m_axis_tdata), 32'(q[0].d));
        chk("m_tlast", 32'(m_axis_tlast), 32'(q[0].l));
        chk("m_tuser", 32'(m_axis_tuser), 32'(q[0].u));
        chk("m_terr",  32'(m_axis_terr),  32'(q[0].e));
      end
      chk("table_valid", 32'(table_valid), 32'(mtv));
      chk("table_depth", 32'(table_depth), 32'(mdepth));
      chk("overflow",    32'(overflow),    32'(movf));
      occ     = q.size() - int'(pop_e);
      exp_wrr = !mtv || (q.size() == 0);
      exp_str = mtv && (occ < 2) && !(s_axis_wr_tvalid && q.size() == 0);
      chk("wr_tready", 32'(s_axis_wr_tready), 32'(exp_wrr));
      chk("s_tready",  32'(s_axis_tready),    32'(exp_str));
      if (pop_e) void'(q.pop_front());
      if (rd_fired) begin
`ifdef LUT_RANGE_CHECK_EN
        b.e = (int'(s_axis_tdata) >= mdepth);
`else
        b.e = 1'b0;
`endif
        b.d = b.e ? 8'h00 : mmem[s_axis_tdata];
        b.l = s_axis_tlast;
        b.u = s_axis_tuser[0];
        q.push_back(b);
      end
      if (wr_fired) begin
        if (!mloading) begin mwp = 0; mdepth = 0; movf = 0; end
        if (mloading && mwp == 0 && mdepth == 256) movf = 1;
        mmem[mwp] = s_axis_wr_tdata;
        mwp = (mwp + 1) % 256;
        if (mdepth < 256) mdepth++;
        mloading = !s_axis_wr_tlast;
        mtv      = s_axis_wr_tlast;
      end
    end
    @(negedge clk);
  endtask

  task automatic wr_beat(input logic [7:0] d, input bit last);
    int n = 0;
    s_axis_wr_tvalid = 1'b1; s_axis_wr_tdata = d; s_axis_wr_tlast = last;
    wr_fired = 0;
    while (!wr_fired && n < 50) begin tick(); n++; end
    chk("wr_accept", 32'(wr_fired), 32'd1);
    s_axis_wr_tvalid = 1'b0;
  endtask

  task automatic rd_beat(input logic [7:0] a, input bit last, input bit user);
    int n = 0;
    s_axis_tvalid = 1'b1; s_axis_tdata = a; s_axis_tlast = last; s_axis_tuser = user;
    rd_fired = 0;
    while (!rd_fired && n < 50) begin tick(); n++; end
    chk("rd_accept", 32'(rd_fired), 32'd1);
    s_axis_tvalid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    s_axis_tvalid = 1'b0; s_axis_wr_tvalid = 1'b0; rdy_mode = 0;
    while (q.size() != 0 && n < 50) begin tick(); n++; end
    tick();
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    // reset and reset values
    tick(); tick();
    rst = 1'b0;
    chk("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_m_tdata",  32'(m_axis_tdata),  32'd0);
    chk("rst_m_tlast",  32'(m_axis_tlast),  32'd0);
    chk("rst_m_tuser",  32'(m_axis_tuser),  32'd0);
    chk("rst_m_terr",   32'(m_axis_terr),   32'd0);
    chk("rst_s_tready", 32'(s_axis_tready), 32'd0);
    chk("rst_wr_tready", 32'(s_axis_wr_tready), 32'd1);
    chk("rst_table_valid", 32'(table_valid), 32'd0);
    chk("rst_depth", 32'(table_depth), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);

    // 4-word load
    wr_beat(8'h11, 0); wr_beat(8'h22, 0); wr_beat(8'h33, 0); wr_beat(8'h44, 1);
    tick();
    chk("load4_valid", 32'(table_valid), 32'd1);
    chk("load4_depth", 32'(table_depth), 32'd4);

    // back-to-back reads
    rdy_mode = 0;
    for (int i = 0; i < 4; i++) rd_beat(8'(i), (i == 3), 1'(i));
    drain();

    // reverse order under toggling backpressure
    rdy_mode = 1; rdy_cnt = 0;
    for (int i = 0; i < 4; i++) rd_beat(8'(3 - i), (i == 0), 1'(i + 1));
    drain();

    // overflow load: 257 beats
    for (int i = 0; i < 257; i++) wr_beat((i == 256) ? 8'hAA : 8'(i), (i == 256));
    tick();
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_depth", 32'(table_depth), 32'd256);
    rd_beat(8'd0, 0, 0); rd_beat(8'd255, 1, 1); rd_beat(8'd1, 0, 1);
    drain();

    // write wins over simultaneous read with empty pipeline
    s_axis_tvalid = 1'b1; s_axis_tdata = 8'd2;
    s_axis_wr_tvalid = 1'b1; s_axis_wr_tdata = 8'h5A; s_axis_wr_tlast = 1'b0;
    tick();
    chk("wr_wins_wr", 32'(wr_fired), 32'd1);
    chk("wr_wins_rd", 32'(rd_fired), 32'd0);
    s_axis_tvalid = 1'b0;
    wr_beat(8'hA5, 1);
    tick();
    chk("load2_depth", 32'(table_depth), 32'd2);
    rd_beat(8'd0, 0, 0); rd_beat(8'd1, 1, 0);
    drain();

    // range boundary: depth 4, addresses 5 and 3
    wr_beat(8'h11, 0); wr_beat(8'h22, 0); wr_beat(8'h33, 0); wr_beat(8'h44, 1);
    rd_beat(8'd5, 0, 1); rd_beat(8'd3, 1, 0); rd_beat(8'd4, 0, 0);
    drain();

    // randomized traffic
    rdy_mode = 2;
    for (int c = 0; c < 600; c++) begin
      s_axis_wr_tvalid = mloading ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 19) == 0);
      s_axis_wr_tdata  = 8'($urandom_range(0, 255));
      s_axis_wr_tlast  = ($urandom_range(0, 4) == 0);
      s_axis_tvalid    = 1'($urandom_range(0, 1));
      s_axis_tdata     = $urandom_range(0, 1) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255));
      s_axis_tlast     = 1'($urandom_range(0, 1));
      s_axis_tuser     = 1'($urandom_range(0, 1));
      tick();
    end
    drain();

    // reset with one beat buffered and one in flight
    wr_beat(8'h77, 0); wr_beat(8'h88, 1);
    rdy_mode = 3;
    s_axis_tvalid = 1'b1; s_axis_tdata = 8'd1; s_axis_tlast = 1'b0; s_axis_tuser = 1'b1;
    tick();
    tick();
    chk("mid_rd_accept2", 32'(rd_fired), 32'd1);
    s_axis_tvalid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("post_rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("post_rst_table_valid", 32'(table_valid), 32'd0);
    chk("post_rst_s_tready", 32'(s_axis_tready), 32'd0);
    rdy_mode = 0;
    for (int i = 0; i < 5; i++) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
